// File: rtl/fault_map_writer_pkg.sv
// rtl/fault_map_writer_pkg.sv - shared state encoding, defaults and popcount for the fault map writer
package fault_map_writer_pkg;

    localparam int MAX_N                   = 64;
    localparam int DEF_SYSTOLIC_SIZE       = 8;
    localparam int DEF_ROW_FAULT_THRESHOLD = 4;
    localparam int DEF_COL_FAULT_THRESHOLD = 4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_COLLECT  = 3'd1;
    localparam logic [2:0] ST_CLASSIFY = 3'd2;
    localparam logic [2:0] ST_WRITE    = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_COLLECT  = ST_COLLECT,
        S_CLASSIFY = ST_CLASSIFY,
        S_WRITE    = ST_WRITE,
        S_DONE     = ST_DONE
    } state_t;

    // Callers zero-extend their SYSTOLIC_SIZE-wide vector into the MAX_N-wide argument.
    function automatic logic [6:0] popcount(input logic [MAX_N-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < MAX_N; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/fault_classifier.sv
// rtl/fault_classifier.sv - combinational row/column fault flagging over the flat NxN fault map
import fault_map_writer_pkg::*;

module fault_classifier #(
    parameter int SYSTOLIC_SIZE       = DEF_SYSTOLIC_SIZE,
    parameter int ROW_FAULT_THRESHOLD = DEF_ROW_FAULT_THRESHOLD,
    parameter int COL_FAULT_THRESHOLD = DEF_COL_FAULT_THRESHOLD
) (
    input  logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] map_flat,
    output logic [SYSTOLIC_SIZE-1:0]               row_flag,
    output logic [SYSTOLIC_SIZE-1:0]               col_flag
);

    localparam int CW = $clog2(SYSTOLIC_SIZE + 1);

    logic [MAX_N-1:0] row_v;
    logic [MAX_N-1:0] col_v;
    logic [CW-1:0]    row_cnt;
    logic [CW-1:0]    col_cnt;

    always_comb begin
        row_flag = '0;
        col_flag = '0;
        row_v    = '0;
        col_v    = '0;
        row_cnt  = '0;
        col_cnt  = '0;
        for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
            row_v = '0;
            col_v = '0;
            for (int c = 0; c < SYSTOLIC_SIZE; c++) begin
                row_v[c] = map_flat[r*SYSTOLIC_SIZE + c];
                col_v[c] = map_flat[c*SYSTOLIC_SIZE + r];
            end
            row_cnt     = CW'(popcount(row_v));
            col_cnt     = CW'(popcount(col_v));
            row_flag[r] = (int'(row_cnt) >= ROW_FAULT_THRESHOLD);
            col_flag[r] = (int'(col_cnt) >= COL_FAULT_THRESHOLD);
        end
    end

endmodule

// File: rtl/fault_map_writer.sv
// rtl/fault_map_writer.sv - accumulates PE mismatches, classifies faults and streams rows to eNVM
import fault_map_writer_pkg::*;

module fault_map_writer #(
    parameter int SYSTOLIC_SIZE       = DEF_SYSTOLIC_SIZE,
    parameter int ADDR_WIDTH          = $clog2(SYSTOLIC_SIZE),
    parameter int ROW_FAULT_THRESHOLD = DEF_ROW_FAULT_THRESHOLD,
    parameter int COL_FAULT_THRESHOLD = DEF_COL_FAULT_THRESHOLD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_diag,
    input  logic                     pe_result_valid,
    input  logic [ADDR_WIDTH-1:0]    pe_result_row,
    input  logic [SYSTOLIC_SIZE-1:0] pe_result_mismatch,
    input  logic                     test_done,
    output logic                     detection_en,
    output logic [ADDR_WIDTH-1:0]    detection_addr,
    output logic [SYSTOLIC_SIZE-1:0] single_pe_detection,
    output logic                     row_fault_detection,
    output logic                     column_fault_detection,
    output logic                     busy,
    output logic                     diag_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

    state_t state_q, state_d;

    logic [SYSTOLIC_SIZE-1:0]               map_q [SYSTOLIC_SIZE];
    logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] map_flat;
    logic [SYSTOLIC_SIZE-1:0]               cls_row_flag, cls_col_flag;
    logic [SYSTOLIC_SIZE-1:0]               row_flag_q, col_flag_q;
    logic [SYSTOLIC_SIZE-1:0]               row_src, col_src;
    logic [ADDR_WIDTH-1:0]                  k_q, k_d;
    logic                                   wr_now;

    logic                     en_d, rowf_d, colf_d, busy_d, done_d;
    logic [ADDR_WIDTH-1:0]    addr_d;
    logic [SYSTOLIC_SIZE-1:0] single_d;

    always_comb begin
        map_flat = '0;
        for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
            map_flat[r*SYSTOLIC_SIZE +: SYSTOLIC_SIZE] = map_q[r];
        end
    end

    fault_classifier #(
        .SYSTOLIC_SIZE      (SYSTOLIC_SIZE),
        .ROW_FAULT_THRESHOLD(ROW_FAULT_THRESHOLD),
        .COL_FAULT_THRESHOLD(COL_FAULT_THRESHOLD)
    ) u_fault_classifier (
        .map_flat(map_flat),
        .row_flag(cls_row_flag),
        .col_flag(cls_col_flag)
    );

    // Outputs are computed for the state being entered so the registered
    // write of row 0 lands in the first WRITE cycle; in CLASSIFY the flags
    // come straight from the classifier since they are being registered now.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        row_src  = row_flag_q;
        col_src  = col_flag_q;
        wr_now   = 1'b0;
        en_d     = 1'b0;
        addr_d   = '0;
        single_d = '0;
        rowf_d   = 1'b0;
        colf_d   = 1'b0;
        done_d   = 1'b0;
        if (start_diag) begin
            state_d = S_COLLECT;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_COLLECT: begin
                    if (test_done) state_d = S_CLASSIFY;
                end
                S_CLASSIFY: begin
                    state_d = S_WRITE;
                    k_d     = '0;
                    row_src = cls_row_flag;
                    col_src = cls_col_flag;
                    wr_now  = 1'b1;
                end
                S_WRITE: begin
                    if (k_q == LAST_K) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        k_d    = k_q + ADDR_WIDTH'(1);
                        wr_now = 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        if (wr_now) begin
            en_d     = 1'b1;
            addr_d   = k_d;
            rowf_d   = row_src[k_d];
            colf_d   = col_src[k_d];
            single_d = row_src[k_d] ? '0 : (map_q[k_d] & ~col_src);
        end
        busy_d = (state_d == S_COLLECT) || (state_d == S_CLASSIFY) || (state_d == S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                <= S_IDLE;
            k_q                    <= '0;
            row_flag_q             <= '0;
            col_flag_q             <= '0;
            detection_en           <= 1'b0;
            detection_addr         <= '0;
            single_pe_detection    <= '0;
            row_fault_detection    <= 1'b0;
            column_fault_detection <= 1'b0;
            busy                   <= 1'b0;
            diag_done              <= 1'b0;
        end else begin
            state_q                <= state_d;
            k_q                    <= k_d;
            detection_en           <= en_d;
            detection_addr         <= addr_d;
            single_pe_detection    <= single_d;
            row_fault_detection    <= rowf_d;
            column_fault_detection <= colf_d;
            busy                   <= busy_d;
            diag_done              <= done_d;
            if (state_q == S_CLASSIFY && !start_diag) begin
                row_flag_q <= cls_row_flag;
                col_flag_q <= cls_col_flag;
            end
        end
    end

    // Sticky OR of mismatch vectors; any start_diag wipes the map.
    always_ff @(posedge clk) begin
        if (rst || start_diag) begin
            for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
                map_q[r] <= '0;
            end
        end else if (state_q == S_COLLECT && pe_result_valid) begin
            map_q[pe_result_row] <= map_q[pe_result_row] | pe_result_mismatch;
        end
    end

endmodule
